seg7_scan_decoder: RTL and testbench

Recovers BCD digits from a multiplexed, active-low seven-segment display bus: the scanned segment and anode lines a display driver produces. The block sits on the monitor side of the display path. It samples each digit strobe, waits for the pattern to settle, and decodes the pattern back to BCD. It assembles a full frame of digits and hands the frame downstream on a valid/ready handshake. Uses include self-check of display drivers and capture of external displays.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan decoder.
// Optional feature macro: SEG7_BLANK_EN (all-off pattern decodes as blank).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_INVALID = 4'hE;
  localparam logic [3:0] BCD_BLANK   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } settle_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low 7-segment pattern to BCD plus error flag.
// Macro SEG7_BLANK_EN: all-off pattern yields BCD_BLANK without error.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  // Table lookup; anything unrecognised is flagged invalid.
  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b1;
    unique case (1'b1)
      (seg == SEG_0): begin bcd = 4'd0; err = 1'b0; end
      (seg == SEG_1): begin bcd = 4'd1; err = 1'b0; end
      (seg == SEG_2): begin bcd = 4'd2; err = 1'b0; end
      (seg == SEG_3): begin bcd = 4'd3; err = 1'b0; end
      (seg == SEG_4): begin bcd = 4'd4; err = 1'b0; end
      (seg == SEG_5): begin bcd = 4'd5; err = 1'b0; end
      (seg == SEG_6): begin bcd = 4'd6; err = 1'b0; end
      (seg == SEG_7): begin bcd = 4'd7; err = 1'b0; end
      (seg == SEG_8): begin bcd = 4'd8; err = 1'b0; end
      (seg == SEG_9): begin bcd = 4'd9; err = 1'b0; end
`ifdef SEG7_BLANK_EN
      (seg == SEG_BLANK): begin
        bcd = BCD_BLANK;
        err = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: settles scanned digit strobes and assembles BCD frames.
// Macro SEG7_BLANK_EN (via seg7_pattern_decode): blank digits are valid.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_drop
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);

  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    an_ok, same;
  settle_t                 state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    cap;
  logic [3:0]              dec_bcd;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] frame_bcd;
  logic [NUM_DIGITS-1:0]   frame_err;
  logic [NUM_DIGITS-1:0]   captured;
  logic                    complete, load;

  assign sel      = ~an_q;
  assign an_ok    = $onehot(sel);
  assign same     = (seg_q == seg_p) && (an_q == an_p);
  assign complete = &captured;
  assign load     = complete && (!frame_valid || frame_ready);

  seg7_pattern_decode u_dec (
    .seg (seg_q),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  // Input sample stage plus one-deep history for stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '1;
      an_q  <= '1;
      seg_p <= '1;
      an_p  <= '1;
    end else begin
      seg_q <= seg_in;
      an_q  <= an_in;
      seg_p <= seg_q;
      an_p  <= an_q;
    end
  end

  // Settle FSM state and saturating dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Settle FSM next state; capture fires once per stable dwell.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    if (!an_ok) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = SETTLE;
          cnt_nx   = CNT_ONE;
        end
        SETTLE: begin
          if (!same) begin
            cnt_nx = CNT_ONE;
          end else if (cnt == CNT_CAP) begin
            cap      = 1'b1;
            cnt_nx   = CNT_SAT;
            state_nx = HELD;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!same) begin
            state_nx = SETTLE;
            cnt_nx   = CNT_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Frame buffer: slot write on capture, captured set cleared on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_bcd <= '0;
      frame_err <= '0;
      captured  <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap && sel[i]) begin
          frame_bcd[4*i +: 4] <= dec_bcd;
          frame_err[i]        <= dec_err;
        end
      end
      captured <= (complete ? '0 : captured) | (cap ? sel : '0);
    end
  end

  // Output handshake: load on completion if free, else drop the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out     <= '0;
      err_out     <= '0;
      frame_valid <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      frame_drop <= complete && !load;
      if (load) begin
        bcd_out     <= frame_bcd;
        err_out     <= frame_err;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed bench for seg7_scan_decoder (4 digits).
// Honours SEG7_BLANK_EN for the blank-digit expectation.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] bcd_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_drop;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int xfer_cnt = 0;
  logic [15:0] got_bcd = '0;
  logic [3:0]  got_err = '0;
  int x0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .bcd_out     (bcd_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_drop  (frame_drop)
  );

  // Record every handshake transfer seen by the consumer.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      xfer_cnt = xfer_cnt + 1;
      got_bcd  = bcd_out;
      got_err  = err_out;
    end
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b0000001;
      1: pat = 7'b1001111;
      2: pat = 7'b0010010;
      3: pat = 7'b0000110;
      4: pat = 7'b1001100;
      5: pat = 7'b0100100;
      6: pat = 7'b0100000;
      7: pat = 7'b0001111;
      8: pat = 7'b0000000;
      9: pat = 7'b0000100;
      default: pat = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [3:0] an, input logic [6:0] seg,
                      input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    scan(4'b1111, 7'b1111111, n);
  endtask

  task automatic frame4(input int d0, input int d1, input int d2,
                        input int d3);
    scan(4'b1110, pat(d0), 8);
    scan(4'b1101, pat(d1), 8);
    scan(4'b1011, pat(d2), 8);
    scan(4'b0111, pat(d3), 8);
    idle(3);
  endtask

  initial begin
    rst_n       = 1'b0;
    an_in       = 4'b1111;
    seg_in      = 7'b1111111;
    frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd",   bcd_out, 16'h0000);
    chk("rst_err",   err_out, 4'b0000);
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_drop",  frame_drop, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame 1,2,3,4 with consumer always ready.
    frame_ready = 1'b1;
    frame4(1, 2, 3, 4);
    chk("f1_xfers", xfer_cnt, 1);
    chk("f1_bcd",   got_bcd, 16'h4321);
    chk("f1_err",   got_err, 4'b0000);
    chk("f1_valid_low", frame_valid, 1'b0);

    // Glitch on digit 0, invalid pattern on digit 2.
    scan(4'b1110, pat(2), 2);
    scan(4'b1110, pat(1), 4);
    scan(4'b1101, pat(5), 8);
    scan(4'b1011, 7'b1111110, 8);
    scan(4'b0111, pat(7), 8);
    idle(3);
    chk("f2_xfers", xfer_cnt, 2);
    chk("f2_bcd",   got_bcd, 16'h7E51);
    chk("f2_err",   got_err, 4'b0100);

    // Backpressure: first frame held, second frame dropped.
    frame_ready = 1'b0;
    frame4(5, 6, 7, 8);
    chk("bp_valid", frame_valid, 1'b1);
    chk("bp_bcd",   bcd_out, 16'h8765);
    chk("bp_err",   err_out, 4'b0000);
    scan(4'b1110, pat(9), 8);
    scan(4'b1101, pat(0), 8);
    scan(4'b1011, pat(1), 8);
    an_in  = 4'b0111;
    seg_in = pat(2);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("drop_c%0d", c), frame_drop, (c == 6));
    end
    idle(2);
    chk("drop_bcd",   bcd_out, 16'h8765);
    chk("drop_valid", frame_valid, 1'b1);
    chk("drop_xfers", xfer_cnt, 2);
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_xfers", xfer_cnt, 3);
    chk("bp_got",   got_bcd, 16'h8765);
    chk("bp_valid_low", frame_valid, 1'b0);
    idle(2);

    // Reset in the middle of a frame.
    scan(4'b1110, pat(3), 8);
    scan(4'b1101, pat(4), 8);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_bcd",   bcd_out, 16'h0000);
    chk("mid_rst_err",   err_out, 4'b0000);
    chk("mid_rst_valid", frame_valid, 1'b0);
    chk("mid_rst_drop",  frame_drop, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    x0 = xfer_cnt;
    scan(4'b1011, pat(7), 8);
    scan(4'b0111, pat(6), 8);
    idle(3);
    chk("post_rst_partial", frame_valid, 1'b0);
    chk("post_rst_nox", xfer_cnt, x0);
    scan(4'b1110, pat(9), 8);
    scan(4'b1101, pat(8), 8);
    idle(3);
    chk("post_rst_xfers", xfer_cnt, x0 + 1);
    chk("post_rst_bcd",   got_bcd, 16'h6789);
    chk("post_rst_err",   got_err, 4'b0000);

    // Blank pattern on digit 3.
    frame4(0, 9, 8, 10);
    chk("blank_xfers", xfer_cnt, x0 + 2);
`ifdef SEG7_BLANK_EN
    chk("blank_bcd", got_bcd, 16'hF890);
    chk("blank_err", got_err, 4'b0000);
`else
    chk("blank_bcd", got_bcd, 16'hE890);
    chk("blank_err", got_err, 4'b1000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
